// File: rtl/sdram_host_port_if.sv
// Host-side request/response bundle for sdram_host_port.
// The host drives requests as master; the port answers as slave.
interface sdram_host_port_if #(
    parameter int HADDR_WIDTH = 24
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [HADDR_WIDTH-1:0] req_addr;
    logic [15:0]            req_wdata;
    logic                   rsp_valid;
    logic [15:0]            rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sdram_host_port.sv
// Host front end for sdram_controller: request FIFO, one-at-a-time issue FSM
// that holds each request until the controller goes busy, read response, watchdog.
module sdram_host_port #(
    parameter int HADDR_WIDTH = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 1023
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sdram_host_port_if.slave              host,
    output logic [HADDR_WIDTH-1:0]        wr_addr_o,
    output logic [15:0]                   wr_data_o,
    output logic                          wr_enable_o,
    output logic [HADDR_WIDTH-1:0]        rd_addr_o,
    output logic                          rd_enable_o,
    input  logic [15:0]                   rd_data_i,
    input  logic                          rd_ready_i,
    input  logic                          busy_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          idle_o,
    output logic                          timeout_err_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int WD_W  = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_WAIT_WR, S_DRAIN} state_t;

    logic                   fifo_we_q    [FIFO_DEPTH];
    logic [HADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [15:0]            fifo_wdata_q [FIFO_DEPTH];

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    state_t                 state_q, state_d;
    logic                   cur_we_q, cur_we_d;
    logic [HADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [15:0]            cur_wdata_q, cur_wdata_d;
    logic                   wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [15:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   tmo_q, tmo_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic                   push, pop, timeout_hit;

    assign host.req_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign push           = host.req_valid && host.req_ready;
    assign pop            = (state_q == S_IDLE) && (level_q != '0);
    assign timeout_hit    = (state_q != S_IDLE) && (wdog_q >= WD_W'(TIMEOUT - 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_we_d    = cur_we_q;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        tmo_d       = tmo_q;
        wdog_d      = wdog_q + WD_W'(1);
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_we_d    = fifo_we_q[rd_ptr_q];
                    cur_addr_d  = fifo_addr_q[rd_ptr_q];
                    cur_wdata_d = fifo_wdata_q[rd_ptr_q];
                    wr_en_d     = fifo_we_q[rd_ptr_q];
                    rd_en_d     = !fifo_we_q[rd_ptr_q];
                    state_d     = S_ISSUE;
                end
            end
            // busy stays low through a refresh, so the request is simply held
            S_ISSUE: begin
                if (busy_i) begin
                    wr_en_d = 1'b0;
                    rd_en_d = 1'b0;
                    state_d = cur_we_q ? S_WAIT_WR : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (rd_ready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rd_data_i;
                    state_d     = S_DRAIN;
                end
            end
            S_WAIT_WR, S_DRAIN: begin
                if (!busy_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Watchdog abort wins over any completion seen in the same cycle
        if (timeout_hit) begin
            tmo_d       = 1'b1;
            state_d     = S_IDLE;
            wr_en_d     = 1'b0;
            rd_en_d     = 1'b0;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = rsp_rdata_q;
        end
        if (state_d == S_IDLE || state_q == S_IDLE) wdog_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            tmo_q       <= 1'b0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            tmo_q       <= tmo_d;
            wdog_q      <= wdog_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by level/state
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]    <= host.req_we;
            fifo_addr_q[wr_ptr_q]  <= host.req_addr;
            fifo_wdata_q[wr_ptr_q] <= host.req_wdata;
        end
        cur_we_q    <= cur_we_d;
        cur_addr_q  <= cur_addr_d;
        cur_wdata_q <= cur_wdata_d;
    end

    assign wr_addr_o      = cur_addr_q;
    assign rd_addr_o      = cur_addr_q;
    assign wr_data_o      = cur_wdata_q;
    assign wr_enable_o    = wr_en_q;
    assign rd_enable_o    = rd_en_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign fifo_level_o   = level_q;
    assign idle_o         = (level_q == '0) && (state_q == S_IDLE);
    assign timeout_err_o  = tmo_q;
endmodule
